seg_scan_decoder: RTL and testbench

Receive-side decoder for the multiplexed 4-digit 7-segment bus driven by the parking-meter display path. It samples the anode select and active-low segment lines on each Dspl_Clk edge and maps each segment pattern back to a 4-bit code. It assembles complete 4-digit frames and converts the decimal value back to binary over multiple cycles. It is used as an on-board loopback checker and as the bench scoreboard for the display path.

---
 rtl/seg_scan_decoder.sv | 165 ++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - 7-segment scan bus decoder: frame assembly and BCD-to-binary conversion
// Samples the multiplexed display bus, rebuilds 4-digit frames and converts error-free frames to binary.
module seg_scan_decoder (
   input  logic        Dspl_Clk,
   input  logic        RESET,
   input  logic [3:0]  Actv_Sel,
   input  logic [6:0]  Dspl_Out,
   output logic [15:0] BCD_Out,
   output logic        Frame_Vld,
   output logic        Dec_Err,
   output logic        Scan_Err,
   output logic [15:0] Bin_Out,
   output logic        Bin_Vld
);

   typedef enum logic {IDLE, CONV} conv_state_e;

   logic [3:0]       Sel_q;
   logic [6:0]       Seg_q;
   logic [3:0][3:0]  dig_q, dig_d;
   logic [3:0]       seen_q, seen_d;
   logic [15:0]      bcd_q, bcd_d;
   logic             dec_err_q, dec_err_d;
   logic             frame_vld_q, frame_vld_d;
   logic             scan_err_q, scan_err_d;
   logic             frame_ok;

   conv_state_e      state_q;
   logic [1:0]       step_q;
   logic [15:0]      shadow_q;
   logic [13:0]      acc_q;
   logic [13:0]      acc_next;
   logic [15:0]      bin_q;
   logic             bin_vld_q;

   logic [3:0]       code;
   logic [3:0]       sel_n;
   logic             sel_ok;
   logic [1:0]       slot;
   logic [3:0]       step_dig;
   logic [3:0]       step_val;

   always_comb begin
      case (Seg_q)
         7'b0000001: code = 4'h0;
         7'b1001111: code = 4'h1;
         7'b0010010: code = 4'h2;
         7'b0000110: code = 4'h3;
         7'b1001100: code = 4'h4;
         7'b0100100: code = 4'h5;
         7'b0100000: code = 4'h6;
         7'b0001111: code = 4'h7;
         7'b0000000: code = 4'h8;
         7'b0000100: code = 4'h9;
         7'b1111111: code = 4'hA;
         7'b0110000: code = 4'hF;
         default:    code = 4'hE;
      endcase
   end

   // Select lines are active-low; a valid scan phase has exactly one low bit.
   assign sel_n  = ~Sel_q;
   assign sel_ok = (sel_n != 4'd0) && ((sel_n & (sel_n - 4'd1)) == 4'd0);

   always_comb begin
      case (sel_n)
         4'b0010: slot = 2'd1;
         4'b0100: slot = 2'd2;
         4'b1000: slot = 2'd3;
         default: slot = 2'd0;
      endcase
   end

   always_comb begin
      dig_d       = dig_q;
      seen_d      = seen_q;
      bcd_d       = bcd_q;
      dec_err_d   = dec_err_q;
      frame_vld_d = 1'b0;
      scan_err_d  = 1'b0;
      frame_ok    = 1'b0;
      if (sel_ok) begin
         dig_d[slot]  = code;
         seen_d[slot] = 1'b1;
         if ((slot == 2'd0) && (seen_d == 4'hF)) begin
            bcd_d     = dig_d;
            dec_err_d = 1'b0;
            for (int i = 0; i < 4; i++) begin
               if (dig_d[i][3:1] == 3'b111) dec_err_d = 1'b1;
            end
            frame_vld_d = 1'b1;
            seen_d      = 4'd0;
            frame_ok    = !dec_err_d;
         end
      end else begin
         seen_d     = 4'd0;
         scan_err_d = 1'b1;
      end
   end

   always_comb begin
      case (step_q)
         2'd0:    step_dig = shadow_q[15:12];
         2'd1:    step_dig = shadow_q[11:8];
         2'd2:    step_dig = shadow_q[7:4];
         default: step_dig = shadow_q[3:0];
      endcase
      step_val = (step_dig == 4'hA) ? 4'd0 : step_dig;
      acc_next = (acc_q << 3) + (acc_q << 1) + {10'd0, step_val};
   end

   always_ff @(posedge Dspl_Clk or posedge RESET) begin
      if (RESET) begin
         Sel_q       <= 4'hF;
         Seg_q       <= 7'h7F;
         dig_q       <= '0;
         seen_q      <= 4'd0;
         bcd_q       <= 16'd0;
         dec_err_q   <= 1'b0;
         frame_vld_q <= 1'b0;
         scan_err_q  <= 1'b0;
         state_q     <= IDLE;
         step_q      <= 2'd0;
         shadow_q    <= 16'd0;
         acc_q       <= 14'd0;
         bin_q       <= 16'd0;
         bin_vld_q   <= 1'b0;
      end else begin
         Sel_q       <= Actv_Sel;
         Seg_q       <= Dspl_Out;
         dig_q       <= dig_d;
         seen_q      <= seen_d;
         bcd_q       <= bcd_d;
         dec_err_q   <= dec_err_d;
         frame_vld_q <= frame_vld_d;
         scan_err_q  <= scan_err_d;
         bin_vld_q   <= 1'b0;
         if (state_q == CONV) begin
            if (step_q == 2'd3) begin
               bin_q     <= {2'b00, acc_next};
               bin_vld_q <= 1'b1;
               state_q   <= IDLE;
            end else begin
               acc_q  <= acc_next;
               step_q <= step_q + 2'd1;
            end
         end
         // A new good frame takes priority: restarts mid-conversion, or chains after step 3.
         if (frame_ok) begin
            shadow_q <= bcd_d;
            acc_q    <= 14'd0;
            step_q   <= 2'd0;
            state_q  <= CONV;
         end
      end
   end

   assign BCD_Out   = bcd_q;
   assign Dec_Err   = dec_err_q;
   assign Frame_Vld = frame_vld_q;
   assign Scan_Err  = scan_err_q;
   assign Bin_Out   = bin_q;
   assign Bin_Vld   = bin_vld_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - table-driven scoreboard bench for seg_scan_decoder
module tb_seg_scan_decoder;

   logic        Dspl_Clk = 1'b0;
   logic        RESET;
   logic [3:0]  Actv_Sel;
   logic [6:0]  Dspl_Out;
   logic [15:0] BCD_Out;
   logic        Frame_Vld;
   logic        Dec_Err;
   logic        Scan_Err;
   logic [15:0] Bin_Out;
   logic        Bin_Vld;

   seg_scan_decoder dut (
      .Dspl_Clk  (Dspl_Clk),
      .RESET     (RESET),
      .Actv_Sel  (Actv_Sel),
      .Dspl_Out  (Dspl_Out),
      .BCD_Out   (BCD_Out),
      .Frame_Vld (Frame_Vld),
      .Dec_Err   (Dec_Err),
      .Scan_Err  (Scan_Err),
      .Bin_Out   (Bin_Out),
      .Bin_Vld   (Bin_Vld)
   );

   always #5 Dspl_Clk = ~Dspl_Clk;

   typedef struct {
      logic [15:0] digs;
      logic [15:0] exp_bcd;
      logic        exp_err;
      logic        exp_conv;
      logic [15:0] exp_bin;
   } vec_t;

   typedef struct {
      int          due;
      logic [15:0] bcd;
      logic        err;
      logic        conv;
      logic [15:0] bin;
   } frm_t;

   typedef struct {
      int          due;
      logic [15:0] bin;
   } binx_t;

   frm_t        frame_q[$];
   binx_t       bin_q[$];
   frm_t        mf;
   binx_t       mb;
   vec_t        vecs[9];
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          scan_err_cnt = 0;
   logic [15:0] bin_model = 16'd0;

   always @(posedge Dspl_Clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_zero(input string name);
      check({name, "_bcd"}, {16'd0, BCD_Out}, 32'd0);
      check({name, "_bin"}, {16'd0, Bin_Out}, 32'd0);
      check({name, "_flags"}, {28'd0, Dec_Err, Frame_Vld, Scan_Err, Bin_Vld}, 32'd0);
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] c);
      case (c)
         4'h0:    return 7'b0000001;
         4'h1:    return 7'b1001111;
         4'h2:    return 7'b0010010;
         4'h3:    return 7'b0000110;
         4'h4:    return 7'b1001100;
         4'h5:    return 7'b0100100;
         4'h6:    return 7'b0100000;
         4'h7:    return 7'b0001111;
         4'h8:    return 7'b0000000;
         4'h9:    return 7'b0000100;
         4'hA:    return 7'b1111111;
         4'hF:    return 7'b0110000;
         default: return 7'b1111110;
      endcase
   endfunction

   task automatic drive_digit(input logic [3:0] sel, input logic [3:0] c);
      @(negedge Dspl_Clk);
      Actv_Sel = sel;
      Dspl_Out = seg_of(c);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge Dspl_Clk);
         Actv_Sel = 4'hF;
         Dspl_Out = 7'h7F;
      end
   endtask

   task automatic drive_frame(input logic [15:0] digs, input logic [15:0] bcd, input logic err,
                              input logic conv, input logic [15:0] bin);
      drive_digit(4'b0111, digs[15:12]);
      drive_digit(4'b1011, digs[11:8]);
      drive_digit(4'b1101, digs[7:4]);
      drive_digit(4'b1110, digs[3:0]);
      frame_q.push_back('{cyc + 2, bcd, err, conv, bin});
   endtask

   always @(negedge Dspl_Clk) begin
      if (!RESET) begin
         if (Scan_Err) scan_err_cnt++;
         if (Bin_Vld) begin
            if (bin_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL bin_unexpected: Bin_Out=%0d with no conversion pending (cycle %0d)", Bin_Out, cyc);
            end else begin
               mb = bin_q.pop_front();
               check("bin_value", {16'd0, Bin_Out}, {16'd0, mb.bin});
               check("bin_latency", cyc, mb.due);
               bin_model = mb.bin;
            end
         end
         if (Frame_Vld) begin
            if (frame_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL frame_unexpected: BCD_Out=%h with no frame pending (cycle %0d)", BCD_Out, cyc);
            end else begin
               mf = frame_q.pop_front();
               check("frame_bcd", {16'd0, BCD_Out}, {16'd0, mf.bcd});
               check("frame_dec_err", {31'd0, Dec_Err}, {31'd0, mf.err});
               check("frame_latency", cyc, mf.due);
               check("bin_hold", {16'd0, Bin_Out}, {16'd0, bin_model});
               if (mf.conv) bin_q.push_back('{cyc + 4, mf.bin});
            end
         end
      end
   end

   initial begin
      vecs[0] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'd1234};
      vecs[1] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'd1234};
      vecs[2] = '{16'hAA45, 16'hAA45, 1'b0, 1'b1, 16'd45};
      vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'd0};
      vecs[4] = '{16'h9999, 16'h9999, 1'b0, 1'b1, 16'd9999};
      vecs[5] = '{16'h0001, 16'h0001, 1'b0, 1'b1, 16'd1};
      vecs[6] = '{16'h8760, 16'h8760, 1'b0, 1'b1, 16'd8760};
      vecs[7] = '{16'h7E00, 16'h7E00, 1'b1, 1'b0, 16'd0};
      vecs[8] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'd0};

      RESET    = 1'b1;
      Actv_Sel = 4'hF;
      Dspl_Out = 7'h7F;
      repeat (3) @(negedge Dspl_Clk);
      check_zero("reset_state");
      RESET = 1'b0;
      idle(3);

      for (int i = 0; i < 9; i++) begin
         drive_frame(vecs[i].digs, vecs[i].exp_bcd, vecs[i].exp_err, vecs[i].exp_conv, vecs[i].exp_bin);
         if (i == 1) scan_err_cnt = 0;
      end

      drive_digit(4'b0111, 4'h1);
      drive_digit(4'b1011, 4'h2);
      drive_digit(4'b0011, 4'h3);
      drive_digit(4'b1101, 4'h3);
      drive_digit(4'b1110, 4'h4);
      drive_frame(16'h5678, 16'h5678, 1'b0, 1'b1, 16'd5678);
      check("scan_err_count", scan_err_cnt, 1);

      idle(10);
      drive_frame(16'h5678, 16'h5678, 1'b0, 1'b0, 16'd0);
      idle(3);
      #2 RESET = 1'b1;
      bin_model = 16'd0;
      #1 check_zero("reset_async");
      repeat (3) @(negedge Dspl_Clk);
      check_zero("reset_hold");
      RESET = 1'b0;

      idle(2);
      drive_frame(16'h1234, 16'h1234, 1'b0, 1'b1, 16'd1234);
      idle(10);
      check("drain_frames", frame_q.size(), 0);
      check("drain_bins", bin_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
